// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: PC width, fetch stride and the bubble instruction.
package mips_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance debug; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, next-PC selection (branch > jump > stall > not-ready > fetch)
// and the IF/ID pipeline register, plus stall/redirect performance counters.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use_hazard_stall,
  input  logic             branch_hazard_flush,
  input  logic             jump_flush,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jump_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc_plus4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;
  logic [PC_W-1:0] pc_plus4;
  logic            redirect;
  logic            stall_applied;

  assign pc_plus4      = pc_q + PC_STEP;
  assign redirect      = branch_hazard_flush | jump_flush;
  assign stall_applied = load_use_hazard_stall & ~redirect;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (branch_hazard_flush) begin
      // The branch is older than a jump decoded behind it, so it wins.
      pc_d    = word_align(branch_target);
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (jump_flush) begin
      pc_d    = word_align(jump_target);
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (load_use_hazard_stall) begin
      pc_d = pc_q;
    end else if (!imem_ready) begin
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      instr_d = imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_applied),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect),
    .count (flush_count)
  );

  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;
endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

PC register, next-PC selection and IF/ID pipeline register for the five-stage MIPS pipeline. It consumes the hazard unit's `load_use_hazard_stall`, `branch_hazard_flush` and `jump_flush` decisions:

- Redirects the PC to branch or jump targets.
- Holds fetch on load-use stalls.
- Inserts bubbles into IF/ID.

It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 00.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  single pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load_use_hazard_stall`  in  1  hold PC and IF/ID this cycle.
- `branch_hazard_flush`  in  1  taken branch resolved in EX; redirect to `branch_target`.
- `jump_flush`  in  1  J/JAL/JR/JALR decoded in ID; redirect to `jump_target`.
- `branch_target`  in  32  EX-stage branch target.
- `jump_target`  in  32  ID-stage jump target (immediate or register).
- `imem_addr`  out  32  instruction memory address; equals the PC register.
- `imem_rdata`  in  32  instruction word for `imem_addr`, valid when `imem_ready`.
- `imem_ready`  in  1  instruction memory has data this cycle.
- `if_id_instr`  out  32  IF/ID instruction.
- `if_id_pc_plus4`  out  32  IF/ID PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `stall_cycles`  out  `CNT_W`  count of applied load-use stall cycles.
- `flush_count`  out  `CNT_W`  count of redirect cycles.

## Operation
- Per-cycle priority: reset > branch flush > jump flush > load-use stall > `imem_ready` low > normal fetch.
- **Branch flush:**
  - PC <= {`branch_target`[31:2], 2'b00}.
  - IF/ID <= bubble (`if_id_instr`=32'h0 NOP, `if_id_pc_plus4`=0, `if_id_valid`=0).
  - Wins over a simultaneous jump, because the branch is the older instruction.
- **Jump flush:** PC <= {`jump_target`[31:2], 2'b00}; IF/ID <= bubble.
- **Load-use stall:** PC and all IF/ID fields hold their current values, regardless of `imem_ready`.
- **`imem_ready` low, no hazard:** PC holds; IF/ID <= bubble.
- **Normal fetch:** PC <= PC+4; IF/ID <= {`imem_rdata`, PC+4, valid=1}.
- **Arithmetic:**
  - PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - PC[1:0] is always 00.
- **`stall_cycles`:**
  - +1 on each edge where the stall is the applied action, i.e. not overridden by a flush.
  - Saturates at all-ones.
- **`flush_count`:**
  - +1 on each edge where branch flush or jump flush is applied; a single +1 if both are asserted.
  - Saturates at all-ones.
- **Reset (asynchronous, any time, including mid-stall or mid-redirect):**
  - PC=`RESET_PC`, `if_id_instr`=0, `if_id_pc_plus4`=0, `if_id_valid`=0, both counters 0.
  - Fetch from `RESET_PC` starts on the first edge after `reset` deasserts.

## Timing
- `imem_addr` is driven directly from the PC flop; there is no combinational path from any input to it.
- **Fetch latency:** the instruction at address A appears in IF/ID on the edge after `imem_addr`=A with `imem_ready`=1.
- **Redirect:** a flush sampled at edge N gives `imem_addr`=target after N. The target instruction is in IF/ID after edge N+1 if ready.
- **Stall:** a stall sampled at edge N freezes all outputs except `stall_cycles` across N.
- All outputs are registered.
- Inputs are sampled only at rising edges; no input is required to be stable outside setup/hold.

## Structure
- Shared package `mips_pkg` holds:
  - `NOP_INSTR` (32'h0000_0000).
  - The PC width constant (32).
  - The `PC_STEP` constant (4).
- Sub-module `sat_counter` (parameter `W`; inputs `clk`, `reset`, `inc`; output `count`), instantiated twice for `stall_cycles` and `flush_count`.
- The PC register, next-PC mux and IF/ID register live in `if_fetch_stage`.

## Test plan
- **Reset then free run:** reset=1 for 2 cycles, `imem_ready`=1, `imem_rdata`=addr-derived word → `imem_addr` 0,4,8,…; IF/ID shows word for 0 with `if_id_pc_plus4`=4, `if_id_valid`=1 one cycle later.
- **Load-use stall:** assert stall for 2 cycles at PC=0x10 → `imem_addr` stays 0x10 and IF/ID frozen for 2 cycles, then resumes at 0x14; `stall_cycles`=2.
- **Simultaneous redirect:** `branch_hazard_flush`=`jump_flush`=`load_use_hazard_stall`=1, `branch_target`=0x100, `jump_target`=0x200 → next `imem_addr`=0x100; `if_id_valid`=0; `flush_count`+1; `stall_cycles` unchanged.
- **Memory not ready:** `imem_ready`=0 for 3 cycles at PC=0x40 → PC holds 0x40; 3 bubbles with `if_id_valid`=0; then 0x40's word enters IF/ID.
- **Wrap and saturation:** PC=32'hFFFF_FFFC with normal fetch → next PC 0 and `if_id_pc_plus4`=0. With `CNT_W`=4, 20 stall cycles → `stall_cycles`=15.
- **Async reset mid-redirect:** assert `reset` between edges during a jump flush → all outputs return to reset values immediately, without waiting for a clock edge.
